// File: rtl/inst_loader_pkg.sv
// Shared types and parameter helpers for the instruction loader.
// Holds the loader state encoding and width derivations.
package inst_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_e;

    // Bytes needed to carry one instruction image.
    function automatic int bytes_per_inst(input int len);
        return (len + 7) / 8;
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int iaddr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Little-endian byte assembly register with its lane counter.
// Collects one instruction image a byte at a time.
module byte_packer
    import inst_loader_pkg::*;
#(
    parameter int INST_LEN       = 17,
    parameter int BYTES_PER_INST = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic [7:0]          byte_i,
    output logic                last_o,
    output logic [INST_LEN-1:0] data_o
);

    localparam int CNT_W = iaddr_w(BYTES_PER_INST);
    localparam int ASM_W = 8 * BYTES_PER_INST;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;

    assign last_o = (cnt_q == CNT_W'(BYTES_PER_INST - 1));
    // Bits above INST_LEN in the last lane are dropped here.
    assign data_o = asm_q[INST_LEN-1:0];

    // Next lane contents and counter for an accepted byte.
    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (push_i) begin
            for (int i = 0; i < BYTES_PER_INST; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    asm_d[i*8 +: 8] = byte_i;
                end
            end
            cnt_d = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Assembly and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader: bytes in, memory writes out.
// Holds the CPU in reset until every entry has been written.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int INST_LEN       = 17,
    parameter int INST_CAP       = 5,
    parameter int BYTES_PER_INST = bytes_per_inst(INST_LEN),
    parameter int IADDR_W        = iaddr_w(INST_CAP)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [IADDR_W-1:0]  wr_addr,
    output logic [INST_LEN-1:0] wr_data,
    output logic                cpu_hold,
    output logic                done
);

    state_e             state_q;
    logic [IADDR_W-1:0] addr_q;
    logic               xfer;
    logic               last;
    logic               restart;

    assign xfer    = in_valid && (state_q == LOAD);
    assign restart = start && ((state_q == IDLE) || (state_q == DONE));

    // Outputs decode straight from the state register.
    assign in_ready = (state_q == LOAD);
    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = addr_q;
    assign cpu_hold = (state_q != DONE);
    assign done     = (state_q == DONE);

    byte_packer #(
        .INST_LEN       (INST_LEN),
        .BYTES_PER_INST (BYTES_PER_INST)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (restart),
        .push_i  (xfer),
        .byte_i  (in_data),
        .last_o  (last),
        .data_o  (wr_data)
    );

    // Load sequencing and write-address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        addr_q  <= '0;
                    end
                end
                LOAD: begin
                    if (xfer && last) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (addr_q == IADDR_W'(INST_CAP - 1)) begin
                        state_q <= DONE;
                    end else begin
                        addr_q  <= addr_q + IADDR_W'(1);
                        state_q <= LOAD;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= LOAD;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write-capture memory.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [16:0] wr_data;
    logic        cpu_hold;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [16:0] mem [5];
    int          nwr = 0;

    logic [7:0]  bytes_a [15] = '{8'h45, 8'h23, 8'h01, 8'haa, 8'hbb,
                                  8'hff, 8'h10, 8'h20, 8'h00, 8'hff,
                                  8'hff, 8'hfe, 8'h01, 8'h80, 8'h03};
    logic [16:0] exp_a [5]    = '{17'h12345, 17'h1BBAA, 17'h02010,
                                  17'h0FFFF, 17'h18001};
    logic [7:0]  bytes_b [15] = '{8'h00, 8'h00, 8'h00, 8'h34, 8'h12,
                                  8'h00, 8'hff, 8'hff, 8'hff, 8'h5a,
                                  8'ha5, 8'h01, 8'h01, 8'h00, 8'hfe};
    logic [16:0] exp_b [5]    = '{17'h00000, 17'h01234, 17'h1FFFF,
                                  17'h1A55A, 17'h00001};

    always #5 clk = ~clk;

    inst_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            nwr = nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = '0;
        nwr = 0;
    endtask

    // Offer one byte after gap idle cycles; hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        logic got;
        got = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 64 && !got; n++) begin
            acc = in_ready;
            tick();
            if (acc) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) chk("byte_accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200 && !done; n++) tick();
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        clear_mem();
        tick();
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en",    32'(wr_en),    32'd0);
        rst = 1'b0;

        // Idle with a byte offered: nothing accepted.
        in_valid = 1'b1;
        in_data  = 8'h45;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Back-to-back stream, cycle-exact timing.
        begin
            int p;
            p = 0;
            in_data = bytes_a[0];
            pulse_start();
            chk("start_in_ready", 32'(in_ready), 32'd1);
            for (int k = 1; k <= 20; k++) begin
                logic acc;
                acc = in_ready;
                tick();
                if (acc) p++;
                in_data = bytes_a[p < 15 ? p : 14];
                if (k % 4 == 3) begin
                    chk("wr_en_slot", 32'(wr_en), 32'd1);
                    chk("wr_addr",    32'(wr_addr), 32'((k - 3) / 4));
                    chk("wr_data",    32'(wr_data), 32'(exp_a[(k - 3) / 4]));
                    chk("write_in_ready", 32'(in_ready), 32'd0);
                end else begin
                    chk("wr_en_idle", 32'(wr_en), 32'd0);
                end
                if (k == 19) chk("done_early", 32'(done), 32'd0);
            end
            chk("t20_done",     32'(done),     32'd1);
            chk("t20_cpu_hold", 32'(cpu_hold), 32'd0);
            chk("t20_in_ready", 32'(in_ready), 32'd0);
            chk("bytes_used",   32'(p),        32'd15);
            tick();
            tick();
            chk("done_hold",     32'(done),     32'd1);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_wr_en",    32'(wr_en),    32'd0);
            in_valid = 1'b0;
        end
        for (int i = 0; i < 5; i++) chk("mem_a", 32'(mem[i]), 32'(exp_a[i]));

        // Restart from DONE, gappy stream, start pulse mid-load.
        clear_mem();
        pulse_start();
        chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done",     32'(done),     32'd0);
        chk("restart_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 15; i++) begin
            send_byte(bytes_a[i], int'($urandom_range(0, 2)));
            if (i == 3) begin
                pulse_start();
                chk("start_in_load", 32'(in_ready), 32'd1);
            end
        end
        wait_done();
        chk("gap_nwr", 32'(nwr), 32'd5);
        for (int i = 0; i < 5; i++) chk("mem_gap", 32'(mem[i]), 32'(exp_a[i]));

        // Reset in the middle of a load.
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(bytes_a[i], 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_wr_en",    32'(wr_en),    32'd0);
        chk("midrst_done",     32'(done),     32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_idle_wr_en", 32'(wr_en),    32'd0);
        chk("midrst_idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        clear_mem();
        pulse_start();
        for (int i = 0; i < 15; i++) send_byte(bytes_b[i], 0);
        wait_done();
        chk("reload_nwr", 32'(nwr), 32'd5);
        for (int i = 0; i < 5; i++) chk("mem_b", 32'(mem[i]), 32'(exp_b[i]));

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_prio_done",     32'(done),     32'd0);
        chk("rst_prio_in_ready", 32'(in_ready), 32'd0);
        chk("rst_prio_cpu_hold", 32'(cpu_hold), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter INST_LEN, default 17, is the instruction width in bits.
REQ-002 Parameter INST_CAP, default 5, is the number of instruction-memory entries to fill.
REQ-003 Parameter BYTES_PER_INST, default 3, equals ceil(INST_LEN/8).
REQ-004 Parameter IADDR_W, default 3, equals clog2(INST_CAP), minimum 1.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  one-cycle pulse that begins a (re)load.
REQ-008 in_data  input  8  byte stream carrying instruction images.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
REQ-011 wr_en  output  1  instruction-memory write strobe.
REQ-012 wr_addr  output  IADDR_W  instruction-memory write address.
REQ-013 wr_data  output  INST_LEN  instruction-memory write data.
REQ-014 cpu_hold  output  1  while high, the pipeline is held in reset.
REQ-015 done  output  1  all INST_CAP entries have been written.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-017 IDLE: in_ready=0, wr_en=0, cpu_hold=1, done=0; start moves the FSM to LOAD with addr=0 and byte_cnt=0.
REQ-018 LOAD: in_ready=1 and each transfer is stored into byte lane byte_cnt of the assembly register, little-endian (first byte goes to bits 7:0).
REQ-019 In LOAD, the transfer with byte_cnt=BYTES_PER_INST-1 moves the FSM to WRITE on the next edge and resets byte_cnt to 0; other transfers increment byte_cnt.
REQ-020 In LOAD, cycles with in_valid=0 change no state; there is no timeout.
REQ-021 WRITE lasts exactly one cycle: wr_en=1, wr_addr=addr, wr_data=assembly[INST_LEN-1:0], in_ready=0.
REQ-022 Assembly bits at or above INST_LEN (upper bits of the last byte) SHALL be ignored.
REQ-023 On leaving WRITE: if addr=INST_CAP-1, go to DONE; otherwise addr increments and the FSM returns to LOAD.
REQ-024 DONE: done=1, cpu_hold=0, in_ready=0, wr_en=0; start returns the FSM to LOAD with addr=0, byte_cnt=0, cpu_hold=1 and done=0 from the next cycle.
REQ-025 start SHALL be ignored in LOAD and WRITE.
REQ-026 wr_en SHALL be 1 only in WRITE; wr_addr and wr_data are don't-care when wr_en=0.
REQ-027 Latency: WRITE follows the last byte of an instruction by 1 cycle.
REQ-028 Minimum load time, with in_valid held high, is INST_CAP×(BYTES_PER_INST+1) cycles after the start cycle; done rises the cycle after the final WRITE.
REQ-029 Bytes offered in IDLE, WRITE or DONE are not accepted and are not lost by the loader; the sender holds them.

Reset
REQ-030 rst=1 at any clock edge, including mid-load, forces IDLE, addr=0, byte_cnt=0, wr_en=0, in_ready=0, cpu_hold=1 and done=0; a partial load is discarded.
REQ-031 rst takes priority over start and over an in-flight transfer in the same cycle.

Structure
REQ-032 The shared package SHALL hold the state enum (IDLE, LOAD, WRITE, DONE) and the BYTES_PER_INST and IADDR_W derivation functions.
REQ-033 The byte-assembly register together with byte_cnt SHALL be one sub-module, byte_packer; the FSM and address counter stay in inst_loader.

Verification
REQ-034 Bench: rst for 1 cycle, start, bytes 45,23,01 (hex) with in_valid held -> one WRITE with wr_addr=0, wr_data=17'h12345, the cycle after the third byte.
REQ-035 Bench: third byte FF for instruction 0 -> wr_data bit16=1 and bits 15:0 taken from bytes 1-2; bits 23:17 ignored.
REQ-036 Bench: 15 bytes streamed back-to-back -> writes at addr 0..4; done=1 and cpu_hold=0 exactly 20 cycles after start; in_ready=0 thereafter.
REQ-037 Bench: random in_valid gaps and a start pulse during LOAD -> identical memory contents, start ignored.
REQ-038 Bench: rst asserted after 7 bytes -> next cycle IDLE, cpu_hold=1, no wr_en; a new start reloads from addr 0.
REQ-039 Bench: start in DONE -> cpu_hold=1 next cycle and a full reload overwrites addr 0..4.
